// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, op-class helpers.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_md_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo} and a divide-by-zero flag.
// Zero latency; no flow control, the sequencer decides when the result is captured.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvs, q, r, quot, rem;

  always_comb begin
    sgn   = (op == MD_MULT) || (op == MD_DIV);
    ext_a = sgn ? {{32{srca[31]}}, srca} : {32'd0, srca};
    ext_b = sgn ? {{32{srcb[31]}}, srcb} : {32'd0, srcb};
    prod  = ext_a * ext_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally.
    neg_a = sgn & srca[31];
    neg_b = sgn & srcb[31];
    mag_a = neg_a ? -srca : srca;
    mag_b = neg_b ? -srcb : srcb;
    dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q     = mag_a / dvs;
    r     = mag_a % dvs;
    quot  = (neg_a ^ neg_b) ? -q : q;
    rem   = neg_a ? -r : r;

    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = is_md_div(op) && (srcb == 32'd0);
    if (op == MD_MULT || op == MD_MULTU) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (is_md_div(op)) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO sequencer: MULT/DIV commit after MULT_CYCLES/DIV_CYCLES busy cycles, MTHI/MTLO in one edge.
// Starts arriving while busy are dropped; stall holds later HI/LO users until the result commits.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        pend_hi, pend_lo;
  logic               pend_zero;
  logic [31:0]        res_hi, res_lo;
  logic               div_zero;
  logic               accept, commit;

  mdu_arith u_arith (
    .op       (op),
    .srca     (srca),
    .srcb     (srcb),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (start && is_md_arith(op)) begin
          accept   = 1'b1;
          state_nx = BUSY;
          cnt_nx   = is_md_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_zero <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        pend_hi   <= res_hi;
        pend_lo   <= res_lo;
        pend_zero <= div_zero;
      end
      if (state == IDLE && start && op == MD_MTHI) hi <= srca;
      if (state == IDLE && start && op == MD_MTLO) lo <= srca;
      // A zero divisor still burns its busy cycles but leaves HI/LO untouched.
      if (commit && !pend_zero) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

  assign busy  = (state == BUSY);
  assign stall = md_use && (busy || (start && is_md_arith(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized plus directed checks of mdu_ctrl against a cycle-level arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srca, srcb;
  logic        md_use;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: remaining busy cycles and pending result.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pvalid;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_arith(input logic [2:0] o);
    return o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU;
  endfunction

  task automatic model_edge();
    longint sa, sb, q, r;
    logic [63:0] up;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pvalid) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      sa = longint'($signed(srca));
      sb = longint'($signed(srcb));
      case (op)
        MD_MULT:  begin q = sa * sb; m_phi = q[63:32]; m_plo = q[31:0]; m_pvalid = 1; m_rem = MC; end
        MD_MULTU: begin up = {32'd0, srca} * {32'd0, srcb}; m_phi = up[63:32]; m_plo = up[31:0];
                        m_pvalid = 1; m_rem = MC; end
        MD_DIV: begin
          m_rem = DC;
          m_pvalid = (srcb != 0);
          if (m_pvalid) begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        MD_DIVU: begin
          m_rem = DC;
          m_pvalid = (srcb != 0);
          if (m_pvalid) begin m_plo = srca / srcb; m_phi = srca % srcb; end
        end
        MD_MTHI: m_hi = srca;
        MD_MTLO: m_lo = srca;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pvalid = 0;
  endtask

  // One clock cycle: drive, check stall before the edge, advance model, check state after.
  task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic u);
    @(negedge clk);
    start = s; op = o; srca = a; srcb = b; md_use = u;
    #1 chk("stall", {31'd0, stall}, {31'd0, u && (m_rem > 0 || (s && model_arith(o)))});
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) cyc(1'b0, MD_NONE, 32'd0, 32'd0, u);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b1; op = MD_MULT; srca = 32'h1234; srcb = 32'h5; md_use = 1'b0;
    model_reset();
    // Reset held with start asserted: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
    end
    @(negedge clk); reset = 1'b0; start = 1'b0; op = MD_NONE;
    idle(3, 1'b0);
    chk("idle_hi", hi, 32'd0);

    // MULT / MULTU of -2 * 3
    cyc(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    for (int i = 0; i < MC; i++) begin
      chk("mult_busy_run", {31'd0, busy}, 32'd1);
      cyc(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    end
    chk("mult_busy_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    cyc(1'b1, MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MC, 1'b0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // DIV -7 / 2, old values visible mid-operation
    cyc(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(4, 1'b0);
    chk("div_mid_hi", hi, 32'h0000_0002);
    chk("div_mid_lo", lo, 32'hFFFF_FFFA);
    idle(DC - 4, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Signed overflow case
    cyc(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    // MTHI/MTLO then DIVU by zero leaves them intact
    cyc(1'b1, MD_MTHI, 32'h1234, 32'd0, 1'b0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    cyc(1'b1, MD_MTLO, 32'h5678, 32'd0, 1'b0);
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    cyc(1'b1, MD_DIVU, 32'd99, 32'd0, 1'b0);
    idle(DC - 1, 1'b0);
    chk("dz_busy_last", {31'd0, busy}, 32'd1);
    idle(1, 1'b0);
    chk("dz_busy_done", {31'd0, busy}, 32'd0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h5678);

    // Stall while busy; a start during busy is ignored
    cyc(1'b1, MD_MULT, 32'd7, 32'd6, 1'b0);
    idle(2, 1'b1);
    cyc(1'b1, MD_MTHI, 32'hDEAD, 32'd0, 1'b1);
    idle(2, 1'b1);
    idle(1, 1'b1);
    chk("stall_drop_hi", hi, 32'd0);
    chk("stall_drop_lo", lo, 32'd42);
    // Back-to-back: start accepted in the first non-busy cycle
    cyc(1'b1, MD_MULTU, 32'd3, 32'd3, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    idle(MC, 1'b0);
    chk("b2b_lo", lo, 32'd9);

    // Reset on busy cycle 3 of a DIV aborts it
    cyc(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    idle(DC + 2, 1'b0);
    chk("abort_nocommit_lo", lo, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 2) == 0, ro, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
    end
    idle(DC + 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
